imem_loader: RTL and testbench

Boot-time writer for the core's instruction memory. It accepts a byte stream over a valid/ready handshake and parses a framed program image: a 16-bit word count, little-endian data words, and an 8-bit checksum. It issues one-cycle word writes to the instruction memory write port, and holds the CPU in reset until a verified image is loaded. It sits between the host link (UART/debug bridge) and the instruction memory, in front of the core's PC reset.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_pack.sv | 46 ++++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader
//                (FSM state encoding, frame header size, checksum width).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Number of header bytes (LEN_LO, LEN_HI) that precede the data bytes
    localparam int c_HDR_BYTES = 2;

    // Width of the running modular checksum over the data bytes
    localparam int c_CSUM_W = 8;

    // Loader state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_pack.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pack
//  Description : Little-endian 4-byte word assembler. Each shifted byte enters
//                at the top so the first byte of a word ends up in bits [7:0].
//                o_word_full flags the cycle after the fourth byte lands.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_shift_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [1:0]  o_byte_cnt,
    output logic        o_word_full
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_cnt;
    logic        r_word_full;

    // Shift register, byte counter and full flag; the flag drops on the next shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word      <= 32'd0;
            r_byte_cnt  <= 2'd0;
            r_word_full <= 1'b0;
        end else if (i_clear) begin
            r_word      <= 32'd0;
            r_byte_cnt  <= 2'd0;
            r_word_full <= 1'b0;
        end else if (i_shift_en) begin
            r_word      <= {i_byte, r_word[31:8]};
            r_byte_cnt  <= r_byte_cnt + 2'd1;
            r_word_full <= (r_byte_cnt == 2'd3);
        end
    end

    assign o_word      = r_word;
    assign o_byte_cnt  = r_byte_cnt;
    assign o_word_full = r_word_full;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction-memory writer. Parses a framed byte
//                stream (16-bit word count, little-endian words, 8-bit sum of
//                data bytes), issues one-cycle word writes and holds the CPU
//                until a verified image is in place.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [15:0] c_DEPTH16 = 16'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [15:0]         r_len;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_words;
    logic [c_CSUM_W-1:0] r_sum;
    logic [ADDR_W-1:0]   r_waddr_hold;
    logic [31:0]         r_wdata_hold;

    logic                w_accept;
    logic                w_load_start;
    logic                w_write;
    logic [15:0]         w_len_full;
    logic [ADDR_W:0]     w_words_nxt;
    logic                w_last_word;

    logic [31:0]         w_word;
    logic [1:0]          w_byte_cnt;
    logic                w_word_full;

    assign w_accept    = s_valid && s_ready;
    assign w_len_full  = {s_data, r_len[7:0]};
    assign w_words_nxt = r_words + 1'b1;
    assign w_last_word = (16'(w_words_nxt) == r_len);

    // Word assembly for the DATA phase; cleared whenever a new load begins
    imem_loader_pack u_pack (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_load_start),
        .i_shift_en  ((r_state == ST_DATA) && w_accept),
        .i_byte      (s_data),
        .o_word      (w_word),
        .o_byte_cnt  (w_byte_cnt),
        .o_word_full (w_word_full)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status decode; start is honoured only in IDLE, DONE and ERR
    always_comb begin
        w_state_nxt  = r_state;
        s_ready      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_hold     = 1'b1;
        w_write      = 1'b0;
        w_load_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load_start = 1'b1;
                    w_state_nxt  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_accept) w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_accept) begin
                    if (w_len_full > c_DEPTH16)  w_state_nxt = ST_ERR;
                    else if (w_len_full == 16'd0) w_state_nxt = ST_CSUM;
                    else                          w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_accept && (w_byte_cnt == 2'd3)) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                w_write     = 1'b1;
                w_state_nxt = w_last_word ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_accept) w_state_nxt = (s_data == r_sum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    w_load_start = 1'b1;
                    w_state_nxt  = ST_LEN_LO;
                end
            end
            ST_ERR: begin
                error = 1'b1;
                if (start) begin
                    w_load_start = 1'b1;
                    w_state_nxt  = ST_LEN_LO;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Length capture, checksum, word index / count, and held write-port values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len        <= 16'd0;
            r_idx        <= '0;
            r_words      <= '0;
            r_sum        <= '0;
            r_waddr_hold <= '0;
            r_wdata_hold <= 32'd0;
        end else if (w_load_start) begin
            r_len   <= 16'd0;
            r_idx   <= '0;
            r_words <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_LEN_LO: if (w_accept) r_len[7:0]  <= s_data;
                ST_LEN_HI: if (w_accept) r_len[15:8] <= s_data;
                ST_DATA:   if (w_accept) r_sum       <= r_sum + s_data;
                ST_WRITE: begin
                    r_idx        <= r_idx + 1'b1;
                    r_words      <= w_words_nxt;
                    r_waddr_hold <= r_idx;
                    r_wdata_hold <= w_word;
                end
                default: ;
            endcase
        end
    end

    // The write port shows the live index/word during WRITE and holds them otherwise
    assign imem_we      = w_write && w_word_full;
    assign imem_waddr   = w_write ? r_idx  : r_waddr_hold;
    assign imem_wdata   = w_write ? w_word : r_wdata_hold;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wr_addr [16];
    logic [31:0]       wr_data [16];
    int                wcount = 0;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Log every memory write seen away from the active edge
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wcount < 16) begin
                wr_addr[wcount] = imem_waddr;
                wr_data[wcount] = imem_wdata;
            end
            wcount = wcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send(input logic [7:0] b);
        int t;
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (s_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("send_timeout", 32'(t), 32'd0);
        @(negedge clk);
    endtask

    task automatic gap(input int gaps);
        if (gaps != 0) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_normal(input logic [7:0] csum, input int gaps);
        logic [7:0] fr [11];
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00};
        fr[10] = csum;
        for (int i = 0; i < 11; i++) begin
            gap(gaps);
            send(fr[i]);
        end
        s_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_ready"},  32'(s_ready),      32'd0);
        chk({tag, "_we"},       32'(imem_we),      32'd0);
        chk({tag, "_waddr"},    32'(imem_waddr),   32'd0);
        chk({tag, "_wdata"},    imem_wdata,        32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_done"},     32'(done),         32'd0);
        chk({tag, "_error"},    32'(error),        32'd0);
        chk({tag, "_hold"},     32'(cpu_hold),     32'd1);
        chk({tag, "_words"},    32'(words_loaded), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        // ---- Normal load, host streaming continuously ----
        pulse_start();
        chk("norm_busy", 32'(busy), 32'd1);
        chk("norm_hold", 32'(cpu_hold), 32'd1);
        chk("norm_ready", 32'(s_ready), 32'd1);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        chk("norm_we_lat", 32'(imem_we), 32'd1);
        chk("norm_we_addr", 32'(imem_waddr), 32'd0);
        chk("norm_we_data", imem_wdata, 32'h00000013);
        chk("norm_write_ready", 32'(s_ready), 32'd0);
        send(8'h33); send(8'h01); send(8'h00); send(8'h00);
        send(8'h47);
        s_valid = 1'b0;
        chk("norm_done", 32'(done), 32'd1);
        chk("norm_error", 32'(error), 32'd0);
        chk("norm_busy_end", 32'(busy), 32'd0);
        chk("norm_hold_end", 32'(cpu_hold), 32'd0);
        chk("norm_words", 32'(words_loaded), 32'd2);
        chk("norm_wcount", 32'(wcount), 32'd2);
        chk("norm_a0", 32'(wr_addr[0]), 32'd0);
        chk("norm_d0", wr_data[0], 32'h00000013);
        chk("norm_a1", 32'(wr_addr[1]), 32'd1);
        chk("norm_d1", wr_data[1], 32'h00000133);
        chk("norm_waddr_hold", 32'(imem_waddr), 32'd1);
        chk("norm_wdata_hold", imem_wdata, 32'h00000133);
        chk("norm_ready_end", 32'(s_ready), 32'd0);

        // ---- Bad checksum; restart from DONE re-asserts hold with busy ----
        wcount = 0;
        pulse_start();
        chk("bad_hold_at_start", 32'(cpu_hold), 32'd1);
        chk("bad_busy_at_start", 32'(busy), 32'd1);
        chk("bad_done_cleared", 32'(done), 32'd0);
        chk("bad_words_cleared", 32'(words_loaded), 32'd0);
        // first two header bytes already covered by send_normal
        send_normal(8'h48, 0);
        chk("bad_error", 32'(error), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_hold", 32'(cpu_hold), 32'd1);
        chk("bad_wcount", 32'(wcount), 32'd2);

        // ---- Oversize header N=65 ----
        wcount = 0;
        pulse_start();
        chk("ovs_error_cleared", 32'(error), 32'd0);
        send(8'h41); send(8'h00);
        s_valid = 1'b0;
        chk("ovs_error", 32'(error), 32'd1);
        chk("ovs_ready", 32'(s_ready), 32'd0);
        chk("ovs_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("ovs_wcount", 32'(wcount), 32'd0);

        // ---- Boundary N=64 header is accepted (enters DATA) ----
        pulse_start();
        send(8'h40); send(8'h00);
        chk("n64_ready", 32'(s_ready), 32'd1);
        chk("n64_error", 32'(error), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ---- Zero length ----
        wcount = 0;
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00);
        s_valid = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_words", 32'(words_loaded), 32'd0);
        chk("zero_wcount", 32'(wcount), 32'd0);

        // ---- Normal load with gaps and garbage on idle cycles ----
        wcount = 0;
        pulse_start();
        send_normal(8'h47, 1);
        @(negedge clk);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_wcount", 32'(wcount), 32'd2);
        chk("gap_d0", wr_data[0], 32'h00000013);
        chk("gap_d1", wr_data[1], 32'h00000133);
        chk("gap_a1", 32'(wr_addr[1]), 32'd1);

        // ---- Reset mid-load after 5 data bytes ----
        pulse_start();
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h33);
        s_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wcount = 0;
        pulse_start();
        send_normal(8'h47, 0);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_wcount", 32'(wcount), 32'd2);
        chk("reload_a0", 32'(wr_addr[0]), 32'd0);
        chk("reload_d0", wr_data[0], 32'h00000013);
        chk("reload_d1", wr_data[1], 32'h00000133);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
